arp_top: RTL and testbench



---
 rtl/arp_top.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_arp_top.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_top.sv
// rtl/arp_top.sv - ARP request/reply transmitter and ARP receiver on a GMII byte interface
//
// crc32_d8: one-byte step of the reflected Ethernet CRC-32 (poly 0x04C11DB7).
//   crc_i   running CRC register
//   data_i  byte to fold in, bit 0 first
//   crc_o   updated CRC register
//
// arp_top: builds and sends 72-byte ARP frames (preamble, SFD, Ethernet header,
// ARP payload, padding, FCS) and parses incoming ARP frames addressed to the board.
//   gmii_clk, sys_rst          clock; asynchronous active-high reset
//   gmii_rx_dv, gmii_rxd       receive byte stream
//   gmii_tx_en, gmii_txd       transmit byte stream (txd forced to 0 when idle)
//   gmii_tx_done               one-cycle pulse after the last FCS byte
//   arp_tx_en, arp_tx_type     start pulse and request(0)/reply(1) select
//   des_mac, des_ip            peer addresses; 0 selects the DES_MAC/DES_IP defaults
//   arp_rx_done, arp_rx_type   valid-frame pulse and request(0)/reply(1) indication
//   src_mac, src_ip            sender fields of the last valid received ARP frame

module crc32_d8 (
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);
  logic [31:0] c;

  always_comb begin
    c = crc_i;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data_i[i]) c = {1'b0, c[31:1]} ^ 32'hEDB8_8320;
      else                  c = {1'b0, c[31:1]};
    end
    crc_o = c;
  end
endmodule

module arp_top #(
  parameter logic [47:0] BOARD_MAC = 48'h00_0a_35_01_fe_c0,
  parameter logic [31:0] BOARD_IP  = 32'hC0_A8_00_02,
  parameter logic [47:0] DES_MAC   = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [31:0] DES_IP    = 32'hC0_A8_00_03
) (
  input  logic        gmii_clk,
  input  logic        sys_rst,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        gmii_tx_en,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_done,
  input  logic        arp_tx_en,
  input  logic        arp_tx_type,
  input  logic [47:0] des_mac,
  input  logic [31:0] des_ip,
  output logic        arp_rx_done,
  output logic        arp_rx_type,
  output logic [47:0] src_mac,
  output logic [31:0] src_ip
);

  // ---------------------------------------------------------------- TX path
  typedef enum logic [2:0] {
    TX_IDLE, TX_PREAMBLE, TX_ETH_HDR, TX_ARP_DATA, TX_PAD, TX_CRC, TX_DONE
  } tx_state_t;

  tx_state_t   tx_state_q, tx_state_d;
  logic [6:0]  tx_cnt_q, tx_cnt_d;      // byte index within the 72-byte frame
  logic        tx_en_q, tx_en_d;
  logic [7:0]  txd_q, txd_d;
  logic        tx_done_q, tx_done_d;
  logic [31:0] crc_q, crc_d;
  logic        type_q, type_d;
  logic [47:0] peer_mac_q, peer_mac_d;
  logic [31:0] peer_ip_q, peer_ip_d;

  logic [47:0]  eth_dst, tgt_mac;
  logic [15:0]  oper;
  logic [399:0] hdr_full, hdr_shift;
  logic [31:0]  fcs, fcs_shift;
  logic [7:0]   tx_byte;
  logic [31:0]  crc_upd;

  // Bytes 0..49 of the frame (preamble through target IP) as one vector,
  // selected by shifting the current byte index into the top byte.
  always_comb begin
    eth_dst  = type_q ? peer_mac_q : 48'hFFFF_FFFF_FFFF;
    tgt_mac  = type_q ? peer_mac_q : 48'h0;
    oper     = type_q ? 16'h0002 : 16'h0001;
    hdr_full = {56'h55_55_55_55_55_55_55, 8'hD5,
                eth_dst, BOARD_MAC, 16'h0806,
                16'h0001, 16'h0800, 8'h06, 8'h04, oper,
                BOARD_MAC, BOARD_IP, tgt_mac, peer_ip_q};
    hdr_shift = hdr_full << {tx_cnt_q, 3'b000};
    fcs       = ~crc_q;
    // FCS goes out least-significant byte first; bytes 68..71 map to cnt[1:0]=0..3.
    fcs_shift = fcs >> {tx_cnt_q[1:0], 3'b000};
    if (tx_cnt_q < 7'd50)      tx_byte = hdr_shift[399:392];
    else if (tx_cnt_q < 7'd68) tx_byte = 8'h00;
    else                       tx_byte = fcs_shift[7:0];
  end

  crc32_d8 u_crc (
    .crc_i  (crc_q),
    .data_i (tx_byte),
    .crc_o  (crc_upd)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_en_d    = 1'b0;
    txd_d      = 8'h00;
    tx_done_d  = 1'b0;
    crc_d      = crc_q;
    type_d     = type_q;
    peer_mac_d = peer_mac_q;
    peer_ip_d  = peer_ip_q;

    case (tx_state_q)
      TX_IDLE: begin
        // The done pulse cycle is still blocked so a new start lands one cycle later.
        if (arp_tx_en && !tx_done_q) begin
          tx_state_d = TX_PREAMBLE;
          tx_cnt_d   = 7'd0;
          crc_d      = 32'hFFFF_FFFF;
          type_d     = arp_tx_type;
          peer_mac_d = (des_mac == 48'h0) ? DES_MAC : des_mac;
          peer_ip_d  = (des_ip == 32'h0) ? DES_IP : des_ip;
        end
      end
      TX_PREAMBLE, TX_ETH_HDR, TX_ARP_DATA, TX_PAD, TX_CRC: begin
        tx_en_d  = 1'b1;
        txd_d    = tx_byte;
        tx_cnt_d = tx_cnt_q + 7'd1;
        if (tx_cnt_q >= 7'd8 && tx_cnt_q < 7'd68) crc_d = crc_upd;
        case (tx_cnt_q)
          7'd7:    tx_state_d = TX_ETH_HDR;
          7'd21:   tx_state_d = TX_ARP_DATA;
          7'd49:   tx_state_d = TX_PAD;
          7'd67:   tx_state_d = TX_CRC;
          7'd71:   tx_state_d = TX_DONE;
          default: tx_state_d = tx_state_q;
        endcase
      end
      TX_DONE: begin
        tx_done_d  = 1'b1;
        tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge gmii_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= 7'd0;
      tx_en_q    <= 1'b0;
      txd_q      <= 8'h00;
      tx_done_q  <= 1'b0;
      crc_q      <= 32'hFFFF_FFFF;
      type_q     <= 1'b0;
      peer_mac_q <= 48'h0;
      peer_ip_q  <= 32'h0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_en_q    <= tx_en_d;
      txd_q      <= txd_d;
      tx_done_q  <= tx_done_d;
      crc_q      <= crc_d;
      type_q     <= type_d;
      peer_mac_q <= peer_mac_d;
      peer_ip_q  <= peer_ip_d;
    end
  end

  assign gmii_tx_en   = tx_en_q;
  assign gmii_txd     = txd_q;
  assign gmii_tx_done = tx_done_q;

  // ---------------------------------------------------------------- RX path
  typedef enum logic [2:0] {
    RX_IDLE, RX_PREAMBLE, RX_ETH_HDR, RX_ARP_DATA, RX_WAIT_END
  } rx_state_t;

  rx_state_t   rx_state_q, rx_state_d;
  logic [5:0]  rx_cnt_q, rx_cnt_d;      // byte index within the frame
  logic [39:0] rx_sh_q, rx_sh_d;        // previous five bytes, newest in the LSBs
  logic        oper_reply_q, oper_reply_d;
  logic [47:0] mac_cap_q, mac_cap_d;
  logic [31:0] ip_cap_q, ip_cap_d;
  logic        rx_done_q, rx_done_d;
  logic        rx_type_q, rx_type_d;
  logic [47:0] src_mac_q, src_mac_d;
  logic [31:0] src_ip_q, src_ip_d;
  logic [47:0] field48;                 // field ending with the current byte

  always_comb begin
    field48      = {rx_sh_q, gmii_rxd};
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_sh_d      = rx_sh_q;
    oper_reply_d = oper_reply_q;
    mac_cap_d    = mac_cap_q;
    ip_cap_d     = ip_cap_q;
    rx_done_d    = 1'b0;
    rx_type_d    = rx_type_q;
    src_mac_d    = src_mac_q;
    src_ip_d     = src_ip_q;

    if (gmii_rx_dv) rx_sh_d = field48[39:0];

    case (rx_state_q)
      RX_IDLE: begin
        if (gmii_rx_dv) begin
          if (gmii_rxd == 8'h55) begin
            rx_state_d = RX_PREAMBLE;
            rx_cnt_d   = 6'd1;
          end else begin
            rx_state_d = RX_WAIT_END;
          end
        end
      end
      RX_PREAMBLE: begin
        if (!gmii_rx_dv) begin
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + 6'd1;
          if (rx_cnt_q == 6'd7) begin
            rx_state_d = (gmii_rxd == 8'hD5) ? RX_ETH_HDR : RX_WAIT_END;
          end else if (gmii_rxd != 8'h55) begin
            rx_state_d = RX_WAIT_END;
          end
        end
      end
      RX_ETH_HDR: begin
        if (!gmii_rx_dv) begin
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + 6'd1;
          if (rx_cnt_q == 6'd13 && field48 != BOARD_MAC &&
              field48 != 48'hFFFF_FFFF_FFFF)
            rx_state_d = RX_WAIT_END;
          if (rx_cnt_q == 6'd21)
            rx_state_d = (field48[15:0] == 16'h0806) ? RX_ARP_DATA : RX_WAIT_END;
        end
      end
      RX_ARP_DATA: begin
        if (!gmii_rx_dv) begin
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + 6'd1;
          if (rx_cnt_q == 6'd29) begin
            if (field48[15:0] == 16'h0001)      oper_reply_d = 1'b0;
            else if (field48[15:0] == 16'h0002) oper_reply_d = 1'b1;
            else                                rx_state_d   = RX_WAIT_END;
          end
          if (rx_cnt_q == 6'd35) mac_cap_d = field48;
          if (rx_cnt_q == 6'd39) ip_cap_d  = field48[31:0];
          if (rx_cnt_q == 6'd49) begin
            rx_state_d = RX_WAIT_END;
            if (field48[31:0] == BOARD_IP) begin
              rx_done_d = 1'b1;
              rx_type_d = oper_reply_q;
              src_mac_d = mac_cap_q;
              src_ip_d  = ip_cap_q;
            end
          end
        end
      end
      RX_WAIT_END: begin
        if (!gmii_rx_dv) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge gmii_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= 6'd0;
      rx_sh_q      <= 40'h0;
      oper_reply_q <= 1'b0;
      mac_cap_q    <= 48'h0;
      ip_cap_q     <= 32'h0;
      rx_done_q    <= 1'b0;
      rx_type_q    <= 1'b0;
      src_mac_q    <= 48'h0;
      src_ip_q     <= 32'h0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_sh_q      <= rx_sh_d;
      oper_reply_q <= oper_reply_d;
      mac_cap_q    <= mac_cap_d;
      ip_cap_q     <= ip_cap_d;
      rx_done_q    <= rx_done_d;
      rx_type_q    <= rx_type_d;
      src_mac_q    <= src_mac_d;
      src_ip_q     <= src_ip_d;
    end
  end

  assign arp_rx_done = rx_done_q;
  assign arp_rx_type = rx_type_q;
  assign src_mac     = src_mac_q;
  assign src_ip      = src_ip_q;

endmodule

// File: tb/tb_arp_top.sv
// tb/tb_arp_top.sv - directed-vector bench for arp_top

module tb_arp_top;

  localparam logic [47:0] BMAC = 48'h00_0a_35_01_fe_c0;
  localparam logic [31:0] BIP  = 32'hC0_A8_00_02;

  logic        gmii_clk;
  logic        sys_rst;
  logic        gmii_rx_dv;
  logic [7:0]  gmii_rxd;
  logic        gmii_tx_en;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_done;
  logic        arp_tx_en;
  logic        arp_tx_type;
  logic [47:0] des_mac;
  logic [31:0] des_ip;
  logic        arp_rx_done;
  logic        arp_rx_type;
  logic [47:0] src_mac;
  logic [31:0] src_ip;

  logic        loop;
  logic        rx_dv_tb;
  logic [7:0]  rxd_tb;

  assign gmii_rx_dv = loop ? gmii_tx_en : rx_dv_tb;
  assign gmii_rxd   = loop ? gmii_txd   : rxd_tb;

  arp_top dut (
    .gmii_clk     (gmii_clk),
    .sys_rst      (sys_rst),
    .gmii_rx_dv   (gmii_rx_dv),
    .gmii_rxd     (gmii_rxd),
    .gmii_tx_en   (gmii_tx_en),
    .gmii_txd     (gmii_txd),
    .gmii_tx_done (gmii_tx_done),
    .arp_tx_en    (arp_tx_en),
    .arp_tx_type  (arp_tx_type),
    .des_mac      (des_mac),
    .des_ip       (des_ip),
    .arp_rx_done  (arp_rx_done),
    .arp_rx_type  (arp_rx_type),
    .src_mac      (src_mac),
    .src_ip       (src_ip)
  );

  initial gmii_clk = 1'b0;
  always #4 gmii_clk = ~gmii_clk;

  int n_vec = 0;
  int n_bad = 0;
  int tx_done_cnt = 0;
  int rx_done_cnt = 0;
  int tx_en_cnt = 0;

  always @(negedge gmii_clk) begin
    if (gmii_tx_done) tx_done_cnt++;
    if (arp_rx_done)  rx_done_cnt++;
    if (gmii_tx_en)   tx_en_cnt++;
  end

  logic [7:0] fb  [0:71];   // expected / injected frame
  logic [7:0] cap [0:71];   // captured transmit frame

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge gmii_clk);
    #1;
  endtask

  // Reference frame: preamble, header, ARP payload, zero pad, then FCS low byte first.
  function automatic void mk(input logic [47:0] dst, input logic [15:0] etype,
                             input logic [15:0] op, input logic [47:0] smac,
                             input logic [31:0] sip, input logic [47:0] tmac,
                             input logic [31:0] tip);
    int k;
    logic [31:0] c;
    k = 0;
    for (int j = 0; j < 7; j++) fb[k++] = 8'h55;
    fb[k++] = 8'hD5;
    for (int j = 5; j >= 0; j--) fb[k++] = dst[8*j +: 8];
    for (int j = 5; j >= 0; j--) fb[k++] = BMAC[8*j +: 8];
    fb[k++] = etype[15:8]; fb[k++] = etype[7:0];
    fb[k++] = 8'h00; fb[k++] = 8'h01; fb[k++] = 8'h08; fb[k++] = 8'h00;
    fb[k++] = 8'h06; fb[k++] = 8'h04;
    fb[k++] = op[15:8]; fb[k++] = op[7:0];
    for (int j = 5; j >= 0; j--) fb[k++] = smac[8*j +: 8];
    for (int j = 3; j >= 0; j--) fb[k++] = sip[8*j +: 8];
    for (int j = 5; j >= 0; j--) fb[k++] = tmac[8*j +: 8];
    for (int j = 3; j >= 0; j--) fb[k++] = tip[8*j +: 8];
    while (k < 68) fb[k++] = 8'h00;
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < 68; i++) begin
      c = c ^ {24'h0, fb[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    c = ~c;
    for (int j = 0; j < 4; j++) fb[68 + j] = c[8*j +: 8];
  endfunction

  function automatic logic [47:0] cap48(input int s);
    return {cap[s], cap[s+1], cap[s+2], cap[s+3], cap[s+4], cap[s+5]};
  endfunction

  function automatic logic [31:0] cap32(input int s);
    return {cap[s], cap[s+1], cap[s+2], cap[s+3]};
  endfunction

  function automatic int frame_diffs();
    int d = 0;
    for (int i = 0; i < 72; i++) if (cap[i] !== fb[i]) d++;
    return d;
  endfunction

  // Start one frame and capture it; busy_at >= 0 pulses arp_tx_en mid-frame.
  task automatic tx_frame(input string tag, input logic typ, input logic [47:0] mac,
                          input logic [31:0] ip, input int busy_at);
    int n = 0;
    int lat = -1;
    logic done_end = 1'b0;
    arp_tx_type = typ; des_mac = mac; des_ip = ip; arp_tx_en = 1'b1;
    tick();
    arp_tx_en = 1'b0;
    check_vec({tag, "_en_before"}, 64'(gmii_tx_en), 64'd0);
    for (int c = 0; c < 120; c++) begin
      tick();
      arp_tx_en = (c == busy_at);
      if (gmii_tx_en) begin
        if (lat < 0) lat = c;
        if (n < 72) cap[n] = gmii_txd;
        n++;
      end else if (n > 0) begin
        done_end = gmii_tx_done;
        break;
      end
    end
    arp_tx_en = 1'b0;
    check_vec({tag, "_latency"}, 64'(lat), 64'd0);
    check_vec({tag, "_len"}, 64'(n), 64'd72);
    check_vec({tag, "_done"}, 64'(done_end), 64'd1);
    tick();
    check_vec({tag, "_done_1cyc"}, 64'(gmii_tx_done), 64'd0);
    check_vec({tag, "_txd_idle"}, 64'(gmii_txd), 64'd0);
  endtask

  task automatic rx_send(input int len);
    for (int i = 0; i < len; i++) begin
      rx_dv_tb = 1'b1;
      rxd_tb   = fb[i];
      tick();
    end
    rx_dv_tb = 1'b0;
    rxd_tb   = 8'h00;
    repeat (4) tick();
  endtask

  int d0, r0, e0;

  initial begin
    sys_rst = 1'b1; loop = 1'b0; rx_dv_tb = 1'b0; rxd_tb = 8'h00;
    arp_tx_en = 1'b0; arp_tx_type = 1'b0; des_mac = 48'h0; des_ip = 32'h0;
    repeat (3) tick();
    check_vec("rst_tx_en", 64'(gmii_tx_en), 64'd0);
    check_vec("rst_txd", 64'(gmii_txd), 64'd0);
    check_vec("rst_tx_done", 64'(gmii_tx_done), 64'd0);
    check_vec("rst_rx_done", 64'(arp_rx_done), 64'd0);
    check_vec("rst_rx_type", 64'(arp_rx_type), 64'd0);
    check_vec("rst_src_mac", 64'(src_mac), 64'd0);
    check_vec("rst_src_ip", 64'(src_ip), 64'd0);
    sys_rst = 1'b0;
    repeat (3) tick();

    // Request with defaults
    mk(48'hFFFF_FFFF_FFFF, 16'h0806, 16'h0001, BMAC, BIP, 48'h0, 32'hC0A8_0003);
    d0 = tx_done_cnt;
    tx_frame("req", 1'b0, 48'h0, 32'h0, -1);
    check_vec("req_pre", 64'({cap[0], cap[6], cap[7]}), 64'h5555D5);
    check_vec("req_dst", 64'(cap48(8)), 64'hFFFF_FFFF_FFFF);
    check_vec("req_src", 64'(cap48(14)), 64'(BMAC));
    check_vec("req_etype", 64'({cap[20], cap[21]}), 64'h0806);
    check_vec("req_oper", 64'({cap[28], cap[29]}), 64'h0001);
    check_vec("req_tmac", 64'(cap48(40)), 64'h0);
    check_vec("req_tip", 64'(cap32(46)), 64'hC0A8_0003);
    check_vec("req_fcs", 64'(cap32(68)), 64'({fb[68], fb[69], fb[70], fb[71]}));
    check_vec("req_frame_diffs", 64'(frame_diffs()), 64'd0);
    check_vec("req_done_cnt", 64'(tx_done_cnt - d0), 64'd1);

    // Reply to explicit peer
    mk(48'h0011_2233_4455, 16'h0806, 16'h0002, BMAC, BIP, 48'h0011_2233_4455, 32'hC0A8_0003);
    tx_frame("rep", 1'b1, 48'h0011_2233_4455, 32'hC0A8_0003, -1);
    check_vec("rep_dst", 64'(cap48(8)), 64'h0011_2233_4455);
    check_vec("rep_oper", 64'({cap[28], cap[29]}), 64'h0002);
    check_vec("rep_tmac", 64'(cap48(40)), 64'h0011_2233_4455);
    check_vec("rep_frame_diffs", 64'(frame_diffs()), 64'd0);

    // RX valid broadcast request
    mk(48'hFFFF_FFFF_FFFF, 16'h0806, 16'h0001, 48'h0011_2233_4455, 32'hC0A8_0003, 48'h0, BIP);
    r0 = rx_done_cnt;
    rx_send(72);
    check_vec("rx_req_done", 64'(rx_done_cnt - r0), 64'd1);
    check_vec("rx_req_type", 64'(arp_rx_type), 64'd0);
    check_vec("rx_req_mac", 64'(src_mac), 64'h0011_2233_4455);
    check_vec("rx_req_ip", 64'(src_ip), 64'hC0A8_0003);

    // RX rejects
    r0 = rx_done_cnt;
    mk(48'hFFFF_FFFF_FFFF, 16'h0806, 16'h0001, 48'h0066_7788_99AA, 32'hC0A8_0004, 48'h0, 32'hC0A8_0009);
    rx_send(72);
    check_vec("rx_bad_tip", 64'(rx_done_cnt - r0), 64'd0);
    mk(48'hFFFF_FFFF_FFFF, 16'h0800, 16'h0001, 48'h0066_7788_99AA, 32'hC0A8_0004, 48'h0, BIP);
    rx_send(72);
    check_vec("rx_bad_etype", 64'(rx_done_cnt - r0), 64'd0);
    mk(48'h0011_2233_4466, 16'h0806, 16'h0001, 48'h0066_7788_99AA, 32'hC0A8_0004, 48'h0, BIP);
    rx_send(72);
    check_vec("rx_bad_dst", 64'(rx_done_cnt - r0), 64'd0);
    check_vec("rx_hold_mac", 64'(src_mac), 64'h0011_2233_4455);
    check_vec("rx_hold_ip", 64'(src_ip), 64'hC0A8_0003);

    // Abort mid-header, then a unicast reply to the board is accepted
    mk(BMAC, 16'h0806, 16'h0002, 48'hAABB_CCDD_EEFF, 32'hC0A8_0007, BMAC, BIP);
    rx_send(16);
    check_vec("rx_abort", 64'(rx_done_cnt - r0), 64'd0);
    rx_send(72);
    check_vec("rx_after_abort", 64'(rx_done_cnt - r0), 64'd1);
    check_vec("rx_rep_type", 64'(arp_rx_type), 64'd1);
    check_vec("rx_rep_mac", 64'(src_mac), 64'hAABB_CCDD_EEFF);
    check_vec("rx_rep_ip", 64'(src_ip), 64'hC0A8_0007);

    // Loopback
    loop = 1'b1;
    r0 = rx_done_cnt;
    tx_frame("lb_req", 1'b0, 48'h0, 32'h0, -1);
    repeat (4) tick();
    check_vec("lb_req_reject", 64'(rx_done_cnt - r0), 64'd0);
    tx_frame("lb_rep", 1'b1, 48'h0, BIP, -1);
    repeat (4) tick();
    check_vec("lb_rep_done", 64'(rx_done_cnt - r0), 64'd1);
    check_vec("lb_rep_type", 64'(arp_rx_type), 64'd1);
    check_vec("lb_rep_mac", 64'(src_mac), 64'(BMAC));
    check_vec("lb_rep_ip", 64'(src_ip), 64'(BIP));
    loop = 1'b0;

    // Start pulse while busy is ignored
    d0 = tx_done_cnt;
    tx_frame("busy", 1'b0, 48'h0, 32'h0, 30);
    e0 = tx_en_cnt;
    repeat (20) tick();
    check_vec("busy_no_second", 64'(tx_en_cnt - e0), 64'd0);
    check_vec("busy_one_done", 64'(tx_done_cnt - d0), 64'd1);

    // Reset mid-frame
    arp_tx_en = 1'b1; arp_tx_type = 1'b0; des_mac = 48'h0; des_ip = 32'h0;
    tick();
    arp_tx_en = 1'b0;
    repeat (20) tick();
    check_vec("rstmid_busy", 64'(gmii_tx_en), 64'd1);
    d0 = tx_done_cnt;
    sys_rst = 1'b1;
    #1;
    check_vec("rstmid_en_drop", 64'(gmii_tx_en), 64'd0);
    check_vec("rstmid_txd", 64'(gmii_txd), 64'd0);
    check_vec("rstmid_src_mac", 64'(src_mac), 64'd0);
    repeat (3) tick();
    sys_rst = 1'b0;
    repeat (10) tick();
    check_vec("rstmid_no_done", 64'(tx_done_cnt - d0), 64'd0);
    check_vec("rstmid_idle", 64'(gmii_tx_en), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
